// File: rtl/ddr_arb_pkg.sv
// Shared encodings for the DDR request arbiter: FSM states and transfer
// direction constants used by the top-level sequencer.
package ddr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TURN     = 2'd1,
    RD_BURST = 2'd2,
    WR_BURST = 2'd3
  } arbState_e;

  localparam logic DIR_RD = 1'b0;
  localparam logic DIR_WR = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among N read requesters. The search starts at the stored
// pointer; on advance the pointer moves to one past the winner.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] cand;
  logic          found;

  // First requester at or after the pointer, wrapping modulo N
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int off = 0; off < N; off++) begin
      cand = IW'((int'(ptr_q) + off) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

  assign any = found;
  assign gnt = found ? (N'(1) << idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance && found) begin
      ptr_q <= (int'(idx) == N - 1) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/ddr_req_arbiter.sv
// Shares the DDR user port between NUM_RD read clients and one write client,
// sequencing each granted burst under ddr_rdy flow control.
module ddr_req_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int NUM_RD        = 2,
  parameter int AW            = 28,
  parameter int LW            = 8,
  parameter int ADDR_INC      = 8,
  parameter int TURN_CYC      = 2,
  parameter int MAX_WR_CONSEC = 4
) (
  input  logic                 ddr_usr_clk,
  input  logic                 sys_rst,
  input  logic [NUM_RD-1:0]    rd_req,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  input  logic [NUM_RD*LW-1:0] rd_len,
  output logic [NUM_RD-1:0]    rd_gnt,
  output logic [NUM_RD-1:0]    rd_done,
  input  logic                 wr_req,
  input  logic [AW-1:0]        wr_addr,
  input  logic [LW-1:0]        wr_len,
  output logic                 wr_gnt,
  output logic                 wr_done,
  input  logic                 ddr_rdy,
  output logic                 ddr_rdreq,
  output logic                 ddr_wrreq,
  output logic [AW-1:0]        ddr_addr,
  output logic                 busy
);

  localparam int IW = $clog2(NUM_RD);
  localparam int SW = $clog2(MAX_WR_CONSEC + 1);

  arbState_e         state_q;
  logic              lastDir_q, dir_q;
  logic [2:0]        turnCnt_q;
  logic [LW-1:0]     remaining_q;
  logic [AW-1:0]     addr_q;
  logic [IW-1:0]     rdIdx_q;
  logic [SW-1:0]     streak_q;
  logic [NUM_RD-1:0] rdGnt_q, rdDone_q;
  logic              wrGnt_q, wrDone_q, rdReq_q, wrReq_q;

  logic [NUM_RD-1:0] rrGnt;
  logic [IW-1:0]     rrIdx;
  logic              rrAny;
  logic              pickWr_d, selDir_d, arbGo_d;
  logic [AW-1:0]     selAddr_d;
  logic [LW-1:0]     selLen_d;

  rr_arbiter #(.N(NUM_RD), .IW(IW)) u_rr (
    .clk     (ddr_usr_clk),
    .rst     (sys_rst),
    .req     (rd_req),
    .advance (arbGo_d && !pickWr_d),
    .gnt     (rrGnt),
    .idx     (rrIdx),
    .any     (rrAny)
  );

  // Writes win unless their streak has saturated while a read is waiting
  always_comb begin
    pickWr_d  = wr_req && !((streak_q == SW'(MAX_WR_CONSEC)) && rrAny);
    selDir_d  = pickWr_d ? DIR_WR : DIR_RD;
    selAddr_d = pickWr_d ? wr_addr : rd_addr[int'(rrIdx)*AW +: AW];
    selLen_d  = pickWr_d ? wr_len  : rd_len[int'(rrIdx)*LW +: LW];
    if (selLen_d == '0) selLen_d = LW'(1);
    arbGo_d   = (state_q == IDLE) && (pickWr_d || rrAny);
  end

  always_ff @(posedge ddr_usr_clk) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      lastDir_q   <= DIR_RD;
      dir_q       <= DIR_RD;
      turnCnt_q   <= '0;
      remaining_q <= '0;
      addr_q      <= '0;
      rdIdx_q     <= '0;
      streak_q    <= '0;
      rdGnt_q     <= '0;
      rdDone_q    <= '0;
      wrGnt_q     <= 1'b0;
      wrDone_q    <= 1'b0;
      rdReq_q     <= 1'b0;
      wrReq_q     <= 1'b0;
    end else begin
      rdGnt_q  <= '0;
      wrGnt_q  <= 1'b0;
      rdDone_q <= '0;
      wrDone_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arbGo_d) begin
            addr_q      <= selAddr_d;
            remaining_q <= selLen_d;
            dir_q       <= selDir_d;
            rdIdx_q     <= rrIdx;
            if (pickWr_d) begin
              wrGnt_q <= 1'b1;
              if (!(|rd_req)) streak_q <= '0;
              else if (streak_q != SW'(MAX_WR_CONSEC)) streak_q <= streak_q + SW'(1);
            end else begin
              rdGnt_q  <= rrGnt;
              streak_q <= '0;
            end
            if ((selDir_d != lastDir_q) && (TURN_CYC > 0)) begin
              state_q   <= TURN;
              turnCnt_q <= 3'(TURN_CYC - 1);
            end else begin
              state_q <= pickWr_d ? WR_BURST : RD_BURST;
              rdReq_q <= !pickWr_d;
              wrReq_q <= pickWr_d;
            end
          end
        end
        TURN: begin
          if (turnCnt_q == '0) begin
            state_q <= (dir_q == DIR_WR) ? WR_BURST : RD_BURST;
            rdReq_q <= (dir_q == DIR_RD);
            wrReq_q <= (dir_q == DIR_WR);
          end else begin
            turnCnt_q <= turnCnt_q - 3'd1;
          end
        end
        RD_BURST, WR_BURST: begin
          if (ddr_rdy) begin
            addr_q      <= addr_q + AW'(ADDR_INC);
            remaining_q <= remaining_q - LW'(1);
            if (remaining_q == LW'(1)) begin
              state_q   <= IDLE;
              rdReq_q   <= 1'b0;
              wrReq_q   <= 1'b0;
              lastDir_q <= dir_q;
              if (dir_q == DIR_WR) wrDone_q <= 1'b1;
              else rdDone_q <= NUM_RD'(1) << rdIdx_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_gnt    = rdGnt_q;
  assign rd_done   = rdDone_q;
  assign wr_gnt    = wrGnt_q;
  assign wr_done   = wrDone_q;
  assign ddr_rdreq = rdReq_q;
  assign ddr_wrreq = wrReq_q;
  assign ddr_addr  = addr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// Directed self-checking bench for ddr_req_arbiter with the default
// parameters (2 read clients, TURN_CYC=2, MAX_WR_CONSEC=4).
module tb_ddr_req_arbiter;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic [1:0]  rd_req;
  logic [55:0] rd_addr;
  logic [15:0] rd_len;
  logic [1:0]  rd_gnt, rd_done;
  logic        wr_req;
  logic [27:0] wr_addr;
  logic [7:0]  wr_len;
  logic        wr_gnt, wr_done;
  logic        ddr_rdy;
  logic        ddr_rdreq, ddr_wrreq;
  logic [27:0] ddr_addr;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ddr_req_arbiter dut (
    .ddr_usr_clk (clk),
    .sys_rst     (sys_rst),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_len      (rd_len),
    .rd_gnt      (rd_gnt),
    .rd_done     (rd_done),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_len      (wr_len),
    .wr_gnt      (wr_gnt),
    .wr_done     (wr_done),
    .ddr_rdy     (ddr_rdy),
    .ddr_rdreq   (ddr_rdreq),
    .ddr_wrreq   (ddr_wrreq),
    .ddr_addr    (ddr_addr),
    .busy        (busy)
  );

  // One cycle: outputs are sampled 1ns after the edge, inputs driven there too
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    sys_rst = 1'b1;
    rd_req  = '0;
    rd_addr = '0;
    rd_len  = '0;
    wr_req  = 1'b0;
    wr_addr = '0;
    wr_len  = '0;
    ddr_rdy = 1'b1;
    step();
    step();
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    rd_req  = 2'b11;
    wr_req  = 1'b1;
    rd_len  = {8'd1, 8'd1};
    step();
    total++;
    if ({rd_gnt, rd_done, wr_gnt, wr_done, ddr_rdreq, ddr_wrreq, busy} !== 9'b0) begin
      bad++;
      $display("[TB] FAIL reset_ctrl got=%b want=0", {rd_gnt, rd_done, wr_gnt, wr_done, ddr_rdreq, ddr_wrreq, busy});
    end
    total++;
    if (ddr_addr !== 28'h0) begin
      bad++;
      $display("[TB] FAIL reset_addr got=%h want=0", ddr_addr);
    end
    applyReset();
    step();
    total++;
    if ({rd_gnt, wr_gnt, ddr_rdreq, ddr_wrreq, busy} !== 7'b0) begin
      bad++;
      $display("[TB] FAIL reset_idle got=%b want=0", {rd_gnt, wr_gnt, ddr_rdreq, ddr_wrreq, busy});
    end
  endtask

  task automatic test_single_read();
    logic [27:0] eAddr [5];
    logic [4:0]  eReq, eGnt, eDone;
    int          beats = 0;
    eAddr = '{28'h100, 28'h108, 28'h110, 28'h118, 28'h118};
    eReq  = 5'b00111;
    eGnt  = 5'b00001;
    eDone = 5'b01000;
    applyReset();
    rd_addr = {28'h0, 28'h100};
    rd_len  = {8'd0, 8'd3};
    rd_req  = 2'b01;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 1) rd_req = 2'b00;
      if (ddr_rdreq && ddr_rdy) beats++;
      total++;
      if (rd_gnt !== {1'b0, eGnt[k-1]}) begin
        bad++;
        $display("[TB] FAIL single_gnt k=%0d got=%b want=%b", k, rd_gnt, {1'b0, eGnt[k-1]});
      end
      total++;
      if (ddr_rdreq !== eReq[k-1] || ddr_wrreq !== 1'b0) begin
        bad++;
        $display("[TB] FAIL single_req k=%0d got=%b%b want=%b0", k, ddr_rdreq, ddr_wrreq, eReq[k-1]);
      end
      total++;
      if (ddr_addr !== eAddr[k-1]) begin
        bad++;
        $display("[TB] FAIL single_addr k=%0d got=%h want=%h", k, ddr_addr, eAddr[k-1]);
      end
      total++;
      if (rd_done !== {1'b0, eDone[k-1]}) begin
        bad++;
        $display("[TB] FAIL single_done k=%0d got=%b want=%b", k, rd_done, {1'b0, eDone[k-1]});
      end
    end
    total++;
    if (beats != 3) begin
      bad++;
      $display("[TB] FAIL single_beats got=%0d want=3", beats);
    end
  endtask

  task automatic test_stall();
    logic [27:0] eAddr [6];
    logic [5:0]  eReq, eDone;
    int          beats = 0;
    eAddr = '{28'h100, 28'h108, 28'h108, 28'h110, 28'h118, 28'h118};
    eReq  = 6'b001111;
    eDone = 6'b010000;
    applyReset();
    rd_addr = {28'h0, 28'h100};
    rd_len  = {8'd0, 8'd3};
    rd_req  = 2'b01;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) rd_req = 2'b00;
      ddr_rdy = (k != 2);
      if (ddr_rdreq && ddr_rdy) beats++;
      total++;
      if (ddr_addr !== eAddr[k-1] || ddr_rdreq !== eReq[k-1]) begin
        bad++;
        $display("[TB] FAIL stall_addr k=%0d got=%h/%b want=%h/%b", k, ddr_addr, ddr_rdreq, eAddr[k-1], eReq[k-1]);
      end
      total++;
      if (rd_done !== {1'b0, eDone[k-1]}) begin
        bad++;
        $display("[TB] FAIL stall_done k=%0d got=%b want=%b", k, rd_done, {1'b0, eDone[k-1]});
      end
    end
    total++;
    if (beats != 3) begin
      bad++;
      $display("[TB] FAIL stall_beats got=%0d want=3", beats);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] eGnt [8];
    eGnt = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    applyReset();
    rd_addr = {28'h300, 28'h200};
    rd_len  = {8'd1, 8'd1};
    rd_req  = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      step();
      total++;
      if (rd_gnt !== eGnt[k-1]) begin
        bad++;
        $display("[TB] FAIL rr_gnt k=%0d got=%b want=%b", k, rd_gnt, eGnt[k-1]);
      end
      if (eGnt[k-1] != 2'b00) begin
        total++;
        if (ddr_addr !== ((eGnt[k-1] == 2'b01) ? 28'h200 : 28'h300)) begin
          bad++;
          $display("[TB] FAIL rr_addr k=%0d got=%h", k, ddr_addr);
        end
      end
    end
    rd_req = 2'b00;
  endtask

  task automatic test_write_starve();
    logic [18:0] eWg, eRg, eWq, eRq;
    eWg = '0; eRg = '0; eWq = '0; eRq = '0;
    eWg[1] = 1'b1; eWg[5] = 1'b1; eWg[7] = 1'b1; eWg[9] = 1'b1; eWg[15] = 1'b1;
    eRg[11] = 1'b1;
    eWq[3] = 1'b1; eWq[5] = 1'b1; eWq[7] = 1'b1; eWq[9] = 1'b1; eWq[17] = 1'b1;
    eRq[13] = 1'b1;
    applyReset();
    rd_addr = {28'h0, 28'h100};
    rd_len  = {8'd0, 8'd1};
    wr_addr = 28'h400;
    wr_len  = 8'd1;
    wr_req  = 1'b1;
    rd_req  = 2'b01;
    for (int k = 1; k <= 18; k++) begin
      step();
      total++;
      if (wr_gnt !== eWg[k] || rd_gnt !== {1'b0, eRg[k]}) begin
        bad++;
        $display("[TB] FAIL starve_gnt k=%0d got=w%b r%b want=w%b r0%b", k, wr_gnt, rd_gnt, eWg[k], eRg[k]);
      end
      total++;
      if (ddr_wrreq !== eWq[k] || ddr_rdreq !== eRq[k]) begin
        bad++;
        $display("[TB] FAIL starve_req k=%0d got=w%b r%b want=w%b r%b", k, ddr_wrreq, ddr_rdreq, eWq[k], eRq[k]);
      end
    end
    wr_req = 1'b0;
    rd_req = 2'b00;
  endtask

  task automatic test_len_zero();
    int wrBeats = 0;
    int dones   = 0;
    applyReset();
    wr_addr = 28'h500;
    wr_len  = 8'd0;
    wr_req  = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 1) wr_req = 1'b0;
      if (ddr_wrreq) wrBeats++;
      if (wr_done) dones++;
      if (k == 3) begin
        total++;
        if (ddr_wrreq !== 1'b1 || ddr_addr !== 28'h500) begin
          bad++;
          $display("[TB] FAIL len0_beat got=%b/%h want=1/500", ddr_wrreq, ddr_addr);
        end
      end
      if (k == 4) begin
        total++;
        if (wr_done !== 1'b1 || ddr_addr !== 28'h508) begin
          bad++;
          $display("[TB] FAIL len0_done got=%b/%h want=1/508", wr_done, ddr_addr);
        end
      end
    end
    total++;
    if (wrBeats != 1 || dones != 1) begin
      bad++;
      $display("[TB] FAIL len0_count got=%0d/%0d want=1/1", wrBeats, dones);
    end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    applyReset();
    rd_addr = {28'h300, 28'h100};
    rd_len  = {8'd2, 8'd5};
    rd_req  = 2'b01;
    step();
    rd_req = 2'b00;
    step();
    total++;
    if (ddr_addr !== 28'h108 || ddr_rdreq !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mid_beat2 got=%h/%b want=108/1", ddr_addr, ddr_rdreq);
    end
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    total++;
    if ({rd_gnt, rd_done, wr_gnt, wr_done, ddr_rdreq, ddr_wrreq, busy} !== 9'b0 || ddr_addr !== 28'h0) begin
      bad++;
      $display("[TB] FAIL mid_reset got=%b/%h want=0/0", {rd_gnt, rd_done, wr_gnt, wr_done, ddr_rdreq, ddr_wrreq, busy}, ddr_addr);
    end
    step();
    if (rd_done != 2'b00) dones++;
    rd_req = 2'b10;
    step();
    rd_req = 2'b00;
    total++;
    if (rd_gnt !== 2'b10 || ddr_rdreq !== 1'b1 || ddr_addr !== 28'h300) begin
      bad++;
      $display("[TB] FAIL mid_regrant got=%b/%b/%h want=10/1/300", rd_gnt, ddr_rdreq, ddr_addr);
    end
    step();
    if (rd_done != 2'b00) dones++;
    step();
    total++;
    if (rd_done !== 2'b10 || ddr_rdreq !== 1'b0 || ddr_addr !== 28'h310) begin
      bad++;
      $display("[TB] FAIL mid_done got=%b/%b/%h want=10/0/310", rd_done, ddr_rdreq, ddr_addr);
    end
    total++;
    if (dones != 0) begin
      bad++;
      $display("[TB] FAIL mid_spurious_done got=%0d want=0", dones);
    end
  endtask

  // Structural invariants watched throughout the run
  always @(negedge clk) begin
    if (sys_rst === 1'b0) begin
      if ((ddr_rdreq && ddr_wrreq) || ($countones({rd_gnt, wr_gnt}) > 1)) begin
        total++;
        bad++;
        $display("[TB] FAIL exclusive got=rq%b wq%b g%b%b", ddr_rdreq, ddr_wrreq, rd_gnt, wr_gnt);
      end
    end
  end

  initial begin
    applyReset();
    test_reset();
    test_single_read();
    test_stall();
    test_round_robin();
    test_write_starve();
    test_len_zero();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ddr_req_arbiter.md
Name: ddr_req_arbiter

Overview:
- Shares the single DDR user port between NUM_RD read clients (weight/feature fetch) and one write client (result store).
- Grants one client at a time, sequences its burst of beats onto ddr_rdreq/ddr_wrreq under ddr_rdy flow control, and generates beat addresses.
- Sits between the layer datapath DMA engines and the DDR controller user interface.
- Its ddr_rdreq/ddr_wrreq/ddr_rdy lines are the same signals monitored by the DDR utilization counters.

Parameters:
- NUM_RD, 2, number of read clients (2..4).
- AW, 28, DDR address width.
- LW, 8, burst-length field width in beats.
- ADDR_INC, 8, address increment per accepted beat.
- TURN_CYC, 2, idle cycles inserted on a read/write direction change (0..7).
- MAX_WR_CONSEC, 4, maximum consecutive write grants while any read is pending.

Ports:
- ddr_usr_clk  in  1  sole clock.
- sys_rst  in  1  synchronous, active-high reset.
- rd_req  in  NUM_RD  per-client read request, held high until rd_gnt.
- rd_addr  in  NUM_RD*AW  per-client start address; client i occupies slice [i*AW +: AW].
- rd_len  in  NUM_RD*LW  per-client beat count; client i occupies slice [i*LW +: LW].
- rd_gnt  out  NUM_RD  one-cycle, one-hot grant pulse.
- rd_done  out  NUM_RD  one-cycle pulse after the client's last beat is accepted.
- wr_req  in  1  write request, held high until wr_gnt.
- wr_addr  in  AW  write start address.
- wr_len  in  LW  write beat count.
- wr_gnt  out  1  grant pulse.
- wr_done  out  1  completion pulse.
- ddr_rdy  in  1  controller accepts a beat this cycle.
- ddr_rdreq  out  1  read beat valid.
- ddr_wrreq  out  1  write beat valid.
- ddr_addr  out  AW  beat address.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs are 0, state is IDLE, round-robin pointer is 0, last_dir is READ, write streak counter is 0. Reset asserted mid-burst aborts the burst at the next edge; no done pulse is generated.
- States: IDLE, TURN, RD_BURST, WR_BURST.
- IDLE, no request pending: remain in IDLE.
- IDLE, request pending: select a winner.
  - wr_req wins over reads unless streak == MAX_WR_CONSEC and any rd_req is high.
  - Among reads, round-robin starts at the pointer; the pointer moves to winner+1 (mod NUM_RD).
- On selection (registered, one edge): pulse the winner's gnt for one cycle, latch addr into ddr_addr, and latch len into remaining (len 0 is treated as 1).
  - If the winner's direction != last_dir and TURN_CYC > 0: go to TURN.
  - Otherwise go directly to RD_BURST or WR_BURST.
- TURN: count TURN_CYC cycles, then enter the latched burst state. Requests are not re-evaluated in TURN.
- RD_BURST / WR_BURST:
  - ddr_rdreq (or ddr_wrreq) is held high for the whole state; a beat is accepted when the request and ddr_rdy are both high.
  - On acceptance: ddr_addr += ADDR_INC (wraps modulo 2^AW) and remaining decrements.
  - ddr_rdy low stalls the burst; ddr_addr and remaining hold.
  - When the last beat is accepted: deassert the request the next cycle, pulse done in that same cycle, set last_dir, and return to IDLE. New arbitration may occur in that IDLE cycle, so one gap cycle minimum separates bursts.
- Streak counter:
  - A write grant increments it when any rd_req is high and clears it otherwise.
  - A read grant clears it.
  - It saturates at MAX_WR_CONSEC.
- Changes to a client's req, addr, or len after its grant are ignored; the burst always completes.
- ddr_rdreq and ddr_wrreq are never high simultaneously, and at most one gnt bit is high in any cycle.

Decomposition:
- Shared package ddr_arb_pkg holds:
  - state encoding (IDLE=0, TURN=1, RD_BURST=2, WR_BURST=3);
  - direction constants DIR_RD and DIR_WR.
- Sub-module rr_arbiter (NUM_RD-wide round-robin pick with pointer update) is instantiated once.
- Burst sequencing stays in the top-level module.

Test Plan:
- Single read: rd_req[0]=1, addr 0x100, len 3, ddr_rdy=1 -> rd_gnt[0] pulses once, then TURN_CYC idle cycles (last_dir READ at reset means none), then ddr_rdreq high 3 cycles with ddr_addr 0x100/0x108/0x110, and rd_done[0] pulses the cycle after the third beat.
- Stall: the same burst with ddr_rdy low on cycle 2 -> the address holds at 0x108 for the stall cycle, there are 3 accepted beats total, and done is delayed by 1 cycle.
- Round-robin: rd_req=2'b11 held, len 1 each -> grant sequence is 0,1,0,1.
- Write priority and starvation: wr_req and rd_req[0] held, len 1 -> grants are W,W,W,W,R0,W..., with 2 TURN cycles before each direction change.
- len=0: wr_len 0 -> exactly one ddr_wrreq beat, then wr_done.
- Reset mid-burst: sys_rst during beat 2 of 5 -> next cycle all outputs are 0 and no done pulse; after release, a fresh request is granted normally.
